// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: the NOP used for bubbles, the PC step and the
// layout of one prefetch queue entry.
package cpu_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int          PC_STEP   = 4;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fq_entry_t;

   function automatic int fqCountWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction memory request/response, redirect input and
// the decode-facing valid/ready handshake with queue occupancy.
interface if_stage_if #(
   parameter int A_WIDTH  = 32,
   parameter int D_WIDTH  = 32,
   parameter int FQ_DEPTH = 4
);
   localparam int CW = $clog2(FQ_DEPTH) + 1;

   logic               imem_re;
   logic [A_WIDTH-1:0] imem_addr;
   logic [D_WIDTH-1:0] imem_rdata;
   logic               redirect_valid;
   logic [A_WIDTH-1:0] redirect_pc;
   logic               id_ready;
   logic               id_valid;
   logic [D_WIDTH-1:0] id_instr;
   logic [A_WIDTH-1:0] id_pc;
   logic [CW-1:0]      fq_count;

   modport master (
      output imem_re, imem_addr,
      input  imem_rdata,
      input  redirect_valid, redirect_pc,
      input  id_ready,
      output id_valid, id_instr, id_pc, fq_count
   );

   modport slave (
      input  imem_re, imem_addr,
      output imem_rdata,
      output redirect_valid, redirect_pc,
      output id_ready,
      input  id_valid, id_instr, id_pc, fq_count
   );

endinterface

// File: rtl/if_stage_fetch_queue.sv
// Power-of-two circular FIFO holding fetched {instr, pc} entries; flush empties
// it in one cycle, and the head is read combinationally from storage.
module fetch_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign w_doPush = i_push && !i_flush;
   assign w_doPop  = i_pop && !i_flush && (r_count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_tail <= r_tail + AW'(1);
         end
         if (w_doPop) begin
            r_head <= r_head + AW'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; stale words are never visible because the
   // consumer gates the head with o_empty.
   always_ff @(posedge clk) begin
      if (!rst && w_doPush) begin
         r_mem[r_tail] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_doPush) begin
         assert (r_count != CW'(DEPTH))
            else $error("fetch_queue overflow: push while full");
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one word read in
// flight and buffers returned words with their PCs for decode.
module if_stage
   import cpu_pkg::*;
#(
   parameter int               A_WIDTH  = 32,
   parameter int               D_WIDTH  = 32,
   parameter int               FQ_DEPTH = 4,
   parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
   input  logic       clk,
   input  logic       rst,
   if_stage_if.master io_bus
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_badDepth
      $error("if_stage: FQ_DEPTH must be a power of two and at least 2");
   end

   logic [A_WIDTH-1:0]         r_fetchPc;
   logic [A_WIDTH-1:0]         r_respPc;
   logic                       r_inflight;
   logic [CW-1:0]              w_count;
   logic [CW:0]                w_occupancy;
   logic                       w_issue;
   logic                       w_push;
   logic                       w_pop;
   logic                       w_empty;
   logic                       w_valid;
   logic [D_WIDTH+A_WIDTH-1:0] w_head;
   logic [D_WIDTH+A_WIDTH-1:0] w_pushData;
   logic [A_WIDTH-1:0]         w_redirPc;

   // Credit counts the queued entries plus the word still in flight, so a push
   // can never find the queue full; a pop in the same cycle earns no credit.
   assign w_occupancy = {1'b0, w_count} + (CW + 1)'(r_inflight);
   assign w_issue     = !rst && !io_bus.redirect_valid &&
                        (w_occupancy < (CW + 1)'(FQ_DEPTH));
   assign w_push      = !rst && !io_bus.redirect_valid && r_inflight;
   assign w_valid     = !rst && !io_bus.redirect_valid && !w_empty;
   assign w_pop       = w_valid && io_bus.id_ready;
   assign w_pushData  = {io_bus.imem_rdata, r_respPc};
   assign w_redirPc   = io_bus.redirect_pc & ~A_WIDTH'(3);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetchPc  <= RESET_PC;
         r_respPc   <= '0;
         r_inflight <= 1'b0;
      end else if (io_bus.redirect_valid) begin
         r_fetchPc  <= w_redirPc;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_respPc  <= r_fetchPc;
            r_fetchPc <= r_fetchPc + A_WIDTH'(PC_STEP);
         end
      end
   end

   fetch_queue #(
      .WIDTH (D_WIDTH + A_WIDTH),
      .DEPTH (FQ_DEPTH)
   ) u_fetchQueue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (io_bus.redirect_valid),
      .i_data  (w_pushData),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign io_bus.imem_re   = w_issue;
   assign io_bus.imem_addr = r_fetchPc;
   assign io_bus.id_valid  = w_valid;
   assign io_bus.id_instr  = w_empty ? D_WIDTH'(NOP_INSTR) : w_head[A_WIDTH +: D_WIDTH];
   assign io_bus.id_pc     = w_empty ? '0 : w_head[A_WIDTH-1:0];
   assign io_bus.fq_count  = w_count;

endmodule
